sisc_exec_ctrl: RTL and testbench

- Execute/control slice of the SISC processor: multi-cycle control FSM, 32-bit ALU with 4-bit status register, and 32-bit writeback mux.
- Sits between the register file and its write port.
- Takes the instruction word and the two register-file read operands.
- Produces register-file write enable, writeback data and status flags.

---
 rtl/sisc_exec_ctrl_if.sv | 25 ++
 rtl/sisc_exec_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sisc_exec_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sisc_exec_ctrl_if.sv
// Operand, instruction and writeback bundle between the SISC register file and its execute/control slice.
// The execute block connects through the slave modport; the register-file side uses master.
interface sisc_exec_ctrl_if;
    logic [31:0] ir;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [31:0] alt_data;
    logic [1:0]  alu_op;
    logic        wb_sel;
    logic        rf_we;
    logic [31:0] wb_data;
    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic        halted;

    modport master (
        output ir, rsa, rsb, alt_data,
        input  alu_op, wb_sel, rf_we, wb_data, alu_result, stat, halted
    );

    modport slave (
        input  ir, rsa, rsb, alt_data,
        output alu_op, wb_sel, rf_we, wb_data, alu_result, stat, halted
    );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// SISC execute/control slice: multi-cycle control FSM, 32-bit ALU with CNVZ status and writeback mux.
// Define EXEC_ROTATE_EN to build the ROL/ROR functions (mm 1000/1001); otherwise those codes act as NOP.
module sisc_exec_ctrl (
    input  logic              clk,
    input  logic              rst_f,
    sisc_exec_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_START0,
        ST_START1,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_ALU_REG = 4'b0001;
    localparam logic [3:0] OP_ALU_IMM = 4'b0010;
    localparam logic [3:0] OP_MOV     = 4'b0011;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    localparam logic [3:0] MM_ADD = 4'b0000;
    localparam logic [3:0] MM_SUB = 4'b0001;
    localparam logic [3:0] MM_AND = 4'b0010;
    localparam logic [3:0] MM_OR  = 4'b0011;
    localparam logic [3:0] MM_XOR = 4'b0100;
    localparam logic [3:0] MM_NOT = 4'b0101;
    localparam logic [3:0] MM_SLL = 4'b0110;
    localparam logic [3:0] MM_SRL = 4'b0111;
`ifdef EXEC_ROTATE_EN
    localparam logic [3:0] MM_ROL = 4'b1000;
    localparam logic [3:0] MM_ROR = 4'b1001;
`endif

    state_t      state_reg, state_next;
    logic [31:0] alu_result_reg, alu_result_next;
    logic [3:0]  stat_reg, stat_next;
    logic [1:0]  alu_op_reg, alu_op_next;
    logic        wb_sel_reg, wb_sel_next;

    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic        mm_valid;
    logic        is_alu;
    logic        is_mov;

    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [32:0] add_sum;
    logic [32:0] sub_diff;
    logic [32:0] shl_ext;
    logic [32:0] shr_ext;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;

    // rd/rs fields are consumed by the register file, not by this slice.
    logic        unused_ir_fields;
    assign unused_ir_fields = ^bus.ir[23:16];

    assign opcode = bus.ir[31:28];
    assign mm     = bus.ir[27:24];
    assign imm    = bus.ir[15:0];

    always_comb begin
        mm_valid = 1'b0;
        case (mm)
            MM_ADD, MM_SUB, MM_AND, MM_OR,
            MM_XOR, MM_NOT, MM_SLL, MM_SRL: mm_valid = 1'b1;
`ifdef EXEC_ROTATE_EN
            MM_ROL, MM_ROR:                 mm_valid = 1'b1;
`endif
            default:                        mm_valid = 1'b0;
        endcase
    end

    // An ALU opcode with an unknown function is squashed here, so it never
    // reaches the result/status registers or the write strobe.
    assign is_alu = ((opcode == OP_ALU_REG) || (opcode == OP_ALU_IMM)) && mm_valid;
    assign is_mov = (opcode == OP_MOV);

    assign op2   = alu_op_reg[0] ? {16'h0000, imm} : bus.rsb;
    assign shamt = op2[4:0];

    assign add_sum  = {1'b0, bus.rsa} + {1'b0, op2};
    assign sub_diff = {1'b0, bus.rsa} - {1'b0, op2};
    // The extra bit catches the last bit shifted out; it stays 0 for a zero amount.
    assign shl_ext  = {1'b0, bus.rsa} << shamt;
    assign shr_ext  = {bus.rsa, 1'b0} >> shamt;

    always_comb begin
        alu_res = 32'h0000_0000;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (mm)
            MM_ADD: begin
                alu_res = add_sum[31:0];
                alu_c   = add_sum[32];
                alu_v   = (bus.rsa[31] == op2[31]) && (alu_res[31] != bus.rsa[31]);
            end
            MM_SUB: begin
                alu_res = sub_diff[31:0];
                alu_c   = sub_diff[32];
                alu_v   = (bus.rsa[31] != op2[31]) && (alu_res[31] != bus.rsa[31]);
            end
            MM_AND: alu_res = bus.rsa & op2;
            MM_OR:  alu_res = bus.rsa | op2;
            MM_XOR: alu_res = bus.rsa ^ op2;
            MM_NOT: alu_res = ~bus.rsa;
            MM_SLL: begin
                alu_res = shl_ext[31:0];
                alu_c   = shl_ext[32];
            end
            MM_SRL: begin
                alu_res = shr_ext[32:1];
                alu_c   = shr_ext[0];
            end
`ifdef EXEC_ROTATE_EN
            MM_ROL: alu_res = (bus.rsa << shamt) | (bus.rsa >> (6'd32 - {1'b0, shamt}));
            MM_ROR: alu_res = (bus.rsa >> shamt) | (bus.rsa << (6'd32 - {1'b0, shamt}));
`endif
            default: begin
                alu_res = 32'h0000_0000;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_reg      <= ST_START0;
            alu_result_reg <= 32'h0000_0000;
            stat_reg       <= 4'h0;
            alu_op_reg     <= 2'b00;
            wb_sel_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            alu_result_reg <= alu_result_next;
            stat_reg       <= stat_next;
            alu_op_reg     <= alu_op_next;
            wb_sel_reg     <= wb_sel_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        alu_result_next = alu_result_reg;
        stat_next       = stat_reg;
        alu_op_next     = alu_op_reg;
        wb_sel_next     = wb_sel_reg;
        case (state_reg)
            ST_START0: state_next = ST_START1;
            ST_START1: state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    state_next  = ST_EXECUTE;
                    alu_op_next = {is_alu, is_alu && (opcode == OP_ALU_IMM)};
                    wb_sel_next = is_mov;
                end
            end
            ST_EXECUTE: begin
                state_next = ST_MEM;
                if (alu_op_reg[1]) begin
                    alu_result_next = alu_res;
                    stat_next       = {alu_c, alu_res[31], alu_v, (alu_res == 32'h0000_0000)};
                end
            end
            ST_MEM: state_next = ST_WRITEBACK;
            ST_WRITEBACK: begin
                state_next  = ST_FETCH;
                alu_op_next = 2'b00;
                wb_sel_next = 1'b0;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_START0;
        endcase
    end

    assign bus.alu_op     = alu_op_reg;
    assign bus.wb_sel     = wb_sel_reg;
    assign bus.rf_we      = (state_reg == ST_WRITEBACK) && (alu_op_reg[1] || wb_sel_reg);
    assign bus.alu_result = alu_result_reg;
    assign bus.stat       = stat_reg;
    assign bus.halted     = (state_reg == ST_HALT);
    assign bus.wb_data    = wb_sel_reg ? bus.alt_data : alu_result_reg;

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Self-checking bench for sisc_exec_ctrl: directed cases, randomized instructions against a
// behavioural ALU model, mid-instruction reset and HALT behaviour.
module tb_sisc_exec_ctrl;

    logic clk = 1'b0;
    logic rst_f;

    sisc_exec_ctrl_if bus();

    sisc_exec_ctrl dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_res;
    logic [3:0]  m_stat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU: arithmetic via wide integers, shifts/rotates one bit at a time.
    function automatic void ref_alu(input logic [3:0] f_mm, input logic [31:0] a, input logic [31:0] b,
                                    output bit ok, output logic [31:0] r, output logic [3:0] flags);
        bit c;
        bit v;
        longint sa;
        longint sb;
        longint ss;
        logic [63:0] u;
        int n;
        c  = 1'b0;
        v  = 1'b0;
        ok = 1'b1;
        r  = 32'h0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        case (f_mm)
            4'd0: begin
                u  = {32'h0, a} + {32'h0, b};
                r  = u[31:0];
                c  = u[32];
                ss = sa + sb;
                v  = (ss > longint'(32'sh7fffffff)) || (ss < longint'(32'sh80000000));
            end
            4'd1: begin
                r  = a - b;
                c  = (a < b);
                ss = sa - sb;
                v  = (ss > longint'(32'sh7fffffff)) || (ss < longint'(32'sh80000000));
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin
                r = a;
                for (int i = 0; i < n; i++) begin
                    c = r[31];
                    r = {r[30:0], 1'b0};
                end
            end
            4'd7: begin
                r = a;
                for (int i = 0; i < n; i++) begin
                    c = r[0];
                    r = {1'b0, r[31:1]};
                end
            end
`ifdef EXEC_ROTATE_EN
            4'd8: begin
                r = a;
                for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
            end
            4'd9: begin
                r = a;
                for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
            end
`endif
            default: ok = 1'b0;
        endcase
        flags = {c, r[31], v, (r == 32'h0)};
    endfunction

    // Starts in FETCH (just after the edge) and returns in the following FETCH.
    task automatic run_instr(input string name, input logic [31:0] ir_v, input logic [31:0] rsa_v,
                             input logic [31:0] rsb_v, input logic [31:0] alt_v);
        logic [3:0]  opc;
        logic [31:0] op2;
        logic [31:0] r;
        logic [3:0]  f;
        bit          ok;
        bit          is_alu;
        bit          is_mov;
        bit          chk_ctrl;
        logic [1:0]  exp_op;
        logic        exp_we;
        logic [31:0] exp_wb;
        bus.ir       = ir_v;
        bus.rsa      = rsa_v;
        bus.rsb      = rsb_v;
        bus.alt_data = alt_v;
        opc      = ir_v[31:28];
        op2      = (opc == 4'd2) ? {16'h0, ir_v[15:0]} : rsb_v;
        ref_alu(ir_v[27:24], rsa_v, op2, ok, r, f);
        is_alu   = ((opc == 4'd1) || (opc == 4'd2)) && ok;
        is_mov   = (opc == 4'd3);
        chk_ctrl = !(((opc == 4'd1) || (opc == 4'd2)) && !ok);
        exp_op   = {is_alu, is_alu && (opc == 4'd2)};
        exp_we   = is_alu || is_mov;
        if (is_alu) begin
            m_res  = r;
            m_stat = f;
        end
        exp_wb = is_mov ? alt_v : m_res;

        check({name, "/we_fetch"}, bus.rf_we, 1'b0);
        step();
        check({name, "/we_decode"}, bus.rf_we, 1'b0);
        step();
        if (chk_ctrl) check({name, "/alu_op_exec"}, bus.alu_op, exp_op);
        check({name, "/wb_sel_exec"}, bus.wb_sel, is_mov);
        check({name, "/we_exec"}, bus.rf_we, 1'b0);
        step();
        check({name, "/alu_result"}, bus.alu_result, m_res);
        check({name, "/stat"}, bus.stat, m_stat);
        check({name, "/we_mem"}, bus.rf_we, 1'b0);
        step();
        check({name, "/we_wb"}, bus.rf_we, exp_we);
        check({name, "/wb_data"}, bus.wb_data, exp_wb);
        check({name, "/wb_sel_wb"}, bus.wb_sel, is_mov);
        if (chk_ctrl) check({name, "/alu_op_wb"}, bus.alu_op, exp_op);
        $display("%s ir=%08h rsa=%08h rsb=%08h res=%08h stat=%04b we=%0d wb=%08h",
                 name, ir_v, rsa_v, rsb_v, bus.alu_result, bus.stat, bus.rf_we, bus.wb_data);
        step();
        check({name, "/we_next"}, bus.rf_we, 1'b0);
        check({name, "/alu_op_clr"}, bus.alu_op, 2'b00);
        check({name, "/wb_sel_clr"}, bus.wb_sel, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  r_opc;
        logic [3:0]  r_mm;
        logic [31:0] r_ir;

        bus.ir       = 32'h0;
        bus.rsa      = 32'h0;
        bus.rsb      = 32'h0;
        bus.alt_data = 32'h0;
        rst_f        = 1'b1;
        step();
        step();
        check("rst/alu_result", bus.alu_result, 32'h0);
        check("rst/stat", bus.stat, 4'h0);
        check("rst/rf_we", bus.rf_we, 1'b0);
        check("rst/halted", bus.halted, 1'b0);
        check("rst/alu_op", bus.alu_op, 2'b00);
        check("rst/wb_sel", bus.wb_sel, 1'b0);
        m_res  = 32'h0;
        m_stat = 4'h0;
        rst_f  = 1'b0;
        step();
        check("start1/rf_we", bus.rf_we, 1'b0);
        step();

        run_instr("idle0", 32'h0000_0000, 32'h0, 32'h0, 32'h0);
        run_instr("idle1", 32'h0000_0000, 32'h1234_5678, 32'h1, 32'h5);
        run_instr("add_reg", 32'h1010_0000, 32'h0000_0005, 32'h0000_0003, 32'h0);
        check("add_reg/stat_val", bus.stat, 4'b0000);
        run_instr("add_imm", 32'h2010_FFFF, 32'hFFFF_0001, 32'h0, 32'h0);
        check("add_imm/stat_val", bus.stat, 4'b1001);
        run_instr("sub_ovf", 32'h1110_0000, 32'h8000_0000, 32'h0000_0001, 32'h0);
        check("sub_ovf/res_val", bus.alu_result, 32'h7FFF_FFFF);
        check("sub_ovf/stat_val", bus.stat, 4'b0010);
        run_instr("mov", 32'h3010_0000, 32'h1, 32'h2, 32'hDEAD_BEEF);
        check("mov/stat_hold", bus.stat, 4'b0010);
        run_instr("sll0", 32'h1610_0000, 32'h8000_0001, 32'h0, 32'h0);
        run_instr("srl1", 32'h2710_0001, 32'h0000_0003, 32'h0, 32'h0);
        run_instr("rol", 32'h1810_0000, 32'h8000_0001, 32'h4, 32'h0);
        run_instr("bad_mm", 32'h1C10_0000, 32'h5, 32'h5, 32'h0);

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: r_opc = 4'd1;
                4, 5, 6:    r_opc = 4'd2;
                7:          r_opc = 4'd3;
                8:          r_opc = 4'd0;
                default:    r_opc = 4'($urandom_range(4, 14));
            endcase
            r_mm = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
            r_ir = {r_opc, r_mm, 8'($urandom), 16'($urandom)};
            run_instr($sformatf("rnd%0d", k), r_ir, pick_operand(), pick_operand(), $urandom);
        end

        // Reset while an instruction sits in MEM: its write must never appear.
        bus.ir  = 32'h1000_0000;
        bus.rsa = 32'h0000_0011;
        bus.rsb = 32'h0000_0022;
        step();
        step();
        step();
        rst_f = 1'b1;
        step();
        check("midrst/rf_we", bus.rf_we, 1'b0);
        check("midrst/alu_result", bus.alu_result, 32'h0);
        check("midrst/stat", bus.stat, 4'h0);
        m_res  = 32'h0;
        m_stat = 4'h0;
        rst_f  = 1'b0;
        step();
        check("midrst/rf_we_start1", bus.rf_we, 1'b0);
        step();
        run_instr("post_rst", 32'h1010_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
        $display("midrst abort checked, post_rst res=%08h stat=%04b", bus.alu_result, bus.stat);

        bus.ir = 32'hF000_0000;
        check("halt/fetch", bus.halted, 1'b0);
        step();
        check("halt/decode", bus.halted, 1'b0);
        step();
        check("halt/enter", bus.halted, 1'b1);
        for (int k = 0; k < 20; k++) begin
            bus.ir  = $urandom;
            bus.rsa = $urandom;
            step();
            check("halt/stay", bus.halted, 1'b1);
            check("halt/rf_we", bus.rf_we, 1'b0);
            check("halt/alu_result", bus.alu_result, m_res);
            check("halt/stat", bus.stat, m_stat);
        end
        $display("halt held 20 cycles res=%08h stat=%04b", bus.alu_result, bus.stat);
        rst_f = 1'b1;
        step();
        check("halt_rst/halted", bus.halted, 1'b0);
        check("halt_rst/alu_result", bus.alu_result, 32'h0);
        check("halt_rst/stat", bus.stat, 4'h0);
        m_res  = 32'h0;
        m_stat = 4'h0;
        rst_f  = 1'b0;
        step();
        step();
        run_instr("restart", 32'h1010_0000, 32'h0000_0005, 32'h0000_0003, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
